fu_div_ctrl: RTL

Sequencing controller for the out-of-order core's divide/remainder functional unit. It accepts one DIV/DIVU/REM/REMU µop at a time from the multiply/divide reservation station and formats 33-bit operands for the external multi-cycle sequential divider. It short-circuits the RISC-V special cases (divide-by-zero, signed overflow) without using the divider, and holds the tagged result until the CDB arbiter grants it. It also handles pipeline flushes, including flushes that arrive while the divider is mid-operation.

---
 rtl/fu_div_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fu_div_ctrl.sv
// Divide/remainder sequencing controller: formats operands for the sequential divider,
// short-circuits RISC-V special cases, holds the tagged result for the CDB, handles flushes.
module fu_div_ctrl #(
  parameter int DIV_CYCLES    = 3,
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     iss_valid,
  output logic                     iss_ready,
  input  logic [2:0]               iss_funct3,
  input  logic [31:0]              iss_rs1_v,
  input  logic [31:0]              iss_rs2_v,
  input  logic [PHYS_REG_BITS-1:0] iss_pd,
  input  logic [ROB_IDX_BITS-1:0]  iss_rob,
  input  logic                     flush,
  output logic                     dv_start,
  output logic [32:0]              dv_a,
  output logic [32:0]              dv_b,
  input  logic                     dv_complete,
  input  logic [32:0]              dv_quotient,
  input  logic [32:0]              dv_remainder,
  output logic                     cdb_valid,
  input  logic                     cdb_grant,
  output logic [31:0]              cdb_data,
  output logic [PHYS_REG_BITS-1:0] cdb_pd,
  output logic [ROB_IDX_BITS-1:0]  cdb_rob,
  output logic                     busy
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               op_rem_q;

  logic               accept;
  logic               op_signed;
  logic               op_rem;
  logic               div_by_zero;
  logic               overflow;
  logic               special;
  logic [31:0]        special_res;
  logic               div_done;
  logic               capture;
  logic               unused_bits;

  assign accept      = iss_valid && iss_ready;
  assign op_signed   = ~iss_funct3[0];
  assign op_rem      = iss_funct3[1];
  assign div_by_zero = (iss_rs2_v == 32'h0);
  assign overflow    = op_signed && (iss_rs1_v == 32'h8000_0000) && (iss_rs2_v == 32'hFFFF_FFFF);
  assign special     = div_by_zero || overflow;
  assign div_done    = (cnt_q == '0) && dv_complete;
  assign capture     = (state_q == S_BUSY) && div_done;
  assign unused_bits = ^{iss_funct3[2], dv_quotient[32], dv_remainder[32]};

  always_comb begin
    special_res = 32'h0;
    if (div_by_zero) special_res = op_rem ? iss_rs1_v : 32'hFFFF_FFFF;
    else             special_res = op_rem ? 32'h0 : 32'h8000_0000;
  end

  assign iss_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && cdb_grant);
  assign dv_start  = (state_q == S_START);
  assign cdb_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_START;
      S_START: state_d = S_BUSY;
      S_BUSY:  if (capture) state_d = S_DONE;
      S_DRAIN: if (div_done) state_d = S_IDLE;
      S_DONE:  if (cdb_grant) state_d = accept ? (special ? S_DONE : S_START) : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A divider already started must run out before the unit is reusable.
    if (flush) begin
      if (state_q == S_START || state_q == S_BUSY) state_d = S_DRAIN;
      else if (state_q != S_DRAIN)                 state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      op_rem_q <= 1'b0;
      dv_a     <= 33'h0;
      dv_b     <= 33'h0;
      cdb_data <= 32'h0;
      cdb_pd   <= '0;
      cdb_rob  <= '0;
    end else begin
      if (state_q == S_START)
        cnt_q <= CNT_W'(DIV_CYCLES);
      else if ((state_q == S_BUSY || state_q == S_DRAIN) && cnt_q != '0)
        cnt_q <= cnt_q - CNT_W'(1);

      if (accept) begin
        op_rem_q <= op_rem;
        dv_a     <= {op_signed & iss_rs1_v[31], iss_rs1_v};
        dv_b     <= {op_signed & iss_rs2_v[31], iss_rs2_v};
        cdb_pd   <= iss_pd;
        cdb_rob  <= iss_rob;
        if (special) cdb_data <= special_res;
      end

      if (capture)
        cdb_data <= op_rem_q ? dv_remainder[31:0] : dv_quotient[31:0];
    end
  end

endmodule
